myc64_prg_loader: RTL and testbench

Byte-stream loader that sits directly upstream of the C64 top level's external memory port (i_ext_we / i_ext_addr / i_ext_data / o_ext_ready). It accepts a .PRG image one byte at a time over a valid/ready stream, treats the first two bytes as the little-endian load address, and writes every following byte into main RAM through the ext port. Each write is held until the top level acknowledges it. Host-side sources (UART, SPI, or a testbench) drive the stream; the block reports completion, end address and errors.

---
 rtl/myc64_prg_loader_pkg.sv | 20 ++
 rtl/myc64_ext_writer.sv | 31 +++
 rtl/myc64_prg_loader.sv | 145 ++++++++++++++
 tb/tb_myc64_prg_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/myc64_prg_loader_pkg.sv
// myc64_prg_loader_pkg: state encoding and BASIC pointer constants shared by the PRG loader.
package myc64_prg_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DRAIN,
        S_DONE
`ifdef MYC64_PRG_LOADER_BASIC_PTR_EN
        , S_PTR
`endif
    } state_t;

    localparam logic [15:0] BASIC_PTR_BASE = 16'h002D;
    localparam int          PTR_WRITES     = 6;

endpackage

// File: rtl/myc64_ext_writer.sv
// myc64_ext_writer: holds one ext-port write request (addr/data/we) until the top level acknowledges it.
module myc64_ext_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_data,
    input  logic        ext_ready,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_data,
    output logic        ack
);

    assign ack = ext_we & ext_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_we   <= 1'b0;
            ext_addr <= 16'h0000;
            ext_data <= 8'h00;
        end else if (req) begin
            ext_we   <= 1'b1;
            ext_addr <= req_addr;
            ext_data <= req_data;
        end else if (ack) begin
            ext_we   <= 1'b0;
        end
    end

endmodule

// File: rtl/myc64_prg_loader.sv
// myc64_prg_loader: streams a .PRG image (2-byte LE load address + data) into C64 RAM via the ext port.
// Define MYC64_PRG_LOADER_BASIC_PTR_EN to also write the end address into the BASIC pointers $2D..$32.
module myc64_prg_loader
    import myc64_prg_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_last,
    output logic        o_byte_ready,
    output logic        o_ext_we,
    output logic [15:0] o_ext_addr,
    output logic [7:0]  o_ext_data,
    input  logic        i_ext_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_end_addr
);

    state_t      state, state_nx;
    logic [15:0] addr;
    logic        last_q;
    logic        accept;
    logic        req;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic        ack;
    logic        data_ack;

`ifdef MYC64_PRG_LOADER_BASIC_PTR_EN
    logic [2:0]  idx;
    logic        ptr_q;
    assign data_ack = ack & ~ptr_q;
`else
    assign data_ack = ack;
`endif

    assign o_byte_ready = (state == S_HDR_LO) | (state == S_HDR_HI) | (state == S_DATA) | (state == S_DRAIN);
    assign accept       = i_byte_valid & o_byte_ready;
    assign o_busy       = state != S_IDLE;
    assign o_done       = state == S_DONE;

    myc64_ext_writer u_writer (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ext_ready (i_ext_ready),
        .ext_we    (o_ext_we),
        .ext_addr  (o_ext_addr),
        .ext_data  (o_ext_data),
        .ack       (ack)
    );

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        req_addr = addr;
        req_data = i_byte_data;
        case (state)
            S_IDLE:   state_nx = i_start ? S_HDR_LO : S_IDLE;
            S_HDR_LO: state_nx = accept ? (i_byte_last ? S_DONE : S_HDR_HI) : S_HDR_LO;
            S_HDR_HI: state_nx = accept ? (i_byte_last ? S_DONE : S_DATA) : S_HDR_HI;
            S_DATA: begin
                req      = accept;
                state_nx = accept ? S_WRITE : S_DATA;
            end
            S_WRITE: begin
`ifdef MYC64_PRG_LOADER_BASIC_PTR_EN
                if (ack && ptr_q)
                    state_nx = (idx == 3'(PTR_WRITES - 1)) ? S_DONE : S_PTR;
                else if (ack && last_q)
                    state_nx = o_err ? S_DONE : S_PTR;
                else
`else
                if (ack && last_q)
                    state_nx = S_DONE;
                else
`endif
                if (ack)
                    state_nx = (addr == 16'hFFFF) ? S_DRAIN : S_DATA;
            end
            S_DRAIN:  state_nx = (accept && i_byte_last) ? S_DONE : S_DRAIN;
`ifdef MYC64_PRG_LOADER_BASIC_PTR_EN
            // Even index writes the low byte of the end address, odd the high byte.
            S_PTR: begin
                req      = 1'b1;
                req_addr = BASIC_PTR_BASE + {13'd0, idx};
                req_data = idx[0] ? o_end_addr[15:8] : o_end_addr[7:0];
                state_nx = S_WRITE;
            end
`endif
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr       <= 16'h0000;
            last_q     <= 1'b0;
            o_err      <= 1'b0;
            o_end_addr <= 16'h0000;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && i_start)
                o_err <= 1'b0;
            if (state == S_HDR_LO && accept)
                addr[7:0] <= i_byte_data;
            if (state == S_HDR_HI && accept)
                addr[15:8] <= i_byte_data;
            if ((state == S_HDR_LO || state == S_HDR_HI) && accept && i_byte_last)
                o_err <= 1'b1;
            if (state == S_DATA && accept)
                last_q <= i_byte_last;
            if (state == S_WRITE && data_ack) begin
                o_end_addr <= addr + 16'd1;
                addr       <= addr + 16'd1;
                if (addr == 16'hFFFF && !last_q)
                    o_err <= 1'b1;
            end
        end
    end

`ifdef MYC64_PRG_LOADER_BASIC_PTR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= 3'd0;
            ptr_q <= 1'b0;
        end else if (state == S_IDLE) begin
            idx   <= 3'd0;
            ptr_q <= 1'b0;
        end else if (state == S_PTR) begin
            ptr_q <= 1'b1;
        end else if (state == S_WRITE && ack && ptr_q) begin
            idx   <= idx + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_myc64_prg_loader.sv
// tb_myc64_prg_loader: directed PRG loads with a write/done scoreboard checked by independent monitors.
module tb_myc64_prg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte_data = 8'h00;
    logic        i_byte_last = 1'b0;
    logic        o_byte_ready;
    logic        o_ext_we;
    logic [15:0] o_ext_addr;
    logic [7:0]  o_ext_data;
    logic        i_ext_ready = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_end_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int ack_delay = 3;
    int wcnt = 0;

    logic [23:0] q_wr[$];
    logic [16:0] q_done[$];
    logic [15:0] cap_addr;
    logic [7:0]  cap_data;
    logic        prev_we = 1'b0;
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    myc64_prg_loader dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte_data  (i_byte_data),
        .i_byte_last  (i_byte_last),
        .o_byte_ready (o_byte_ready),
        .o_ext_we     (o_ext_we),
        .o_ext_addr   (o_ext_addr),
        .o_ext_data   (o_ext_data),
        .i_ext_ready  (i_ext_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_end_addr   (o_end_addr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Acknowledge each write ack_delay cycles after o_ext_we rises, as a one-cycle pulse.
    initial forever begin
        @(negedge clk);
        if (i_ext_ready) begin
            i_ext_ready = 1'b0;
            wcnt = 0;
        end else if (o_ext_we && !rst) begin
            wcnt++;
            if (wcnt >= ack_delay) i_ext_ready = 1'b1;
        end else begin
            wcnt = 0;
        end
    end

    // Write monitor: pop on each new request, then require a stable request with ready low.
    always @(negedge clk) begin
        if (o_ext_we && !prev_we) begin
            if (q_wr.size() == 0) begin
                chk("unexpected_write", {8'h0, o_ext_addr, o_ext_data}, 32'hFFFFFFFF);
            end else begin
                logic [23:0] e;
                e = q_wr.pop_front();
                chk("write_addr", {16'h0, o_ext_addr}, {16'h0, e[23:8]});
                chk("write_data", {24'h0, o_ext_data}, {24'h0, e[7:0]});
            end
            cap_addr = o_ext_addr;
            cap_data = o_ext_data;
        end else if (o_ext_we) begin
            chk("hold_addr", {16'h0, o_ext_addr}, {16'h0, cap_addr});
            chk("hold_data", {24'h0, o_ext_data}, {24'h0, cap_data});
            chk("ready_low_in_write", {31'h0, o_byte_ready}, 32'h0);
        end
        prev_we = o_ext_we;
    end

    // Done monitor: compare error flag and end address, and require a single-cycle pulse.
    always @(negedge clk) begin
        if (o_done) begin
            chk("done_single_cycle", {31'h0, prev_done}, 32'h0);
            if (!prev_done) begin
                n_done++;
                if (q_done.size() == 0) begin
                    chk("unexpected_done", {15'h0, o_err, o_end_addr}, 32'hFFFFFFFF);
                end else begin
                    logic [16:0] e;
                    e = q_done.pop_front();
                    chk("done_err", {31'h0, o_err}, {31'h0, e[16]});
                    chk("done_end_addr", {16'h0, o_end_addr}, {16'h0, e[15:0]});
                end
            end
        end
        prev_done = o_done;
    end

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        q_wr.push_back({a, d});
    endtask

    task automatic exp_done(input logic err, input logic [15:0] end_a);
        q_done.push_back({err, end_a});
`ifdef MYC64_PRG_LOADER_BASIC_PTR_EN
        if (!err)
            for (int k = 0; k < 6; k++)
                exp_wr(16'h002D + 16'(k), k[0] ? end_a[15:8] : end_a[7:0]);
`endif
    endtask

    task automatic start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int t;
        @(negedge clk);
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        i_byte_last  = last;
        t = 0;
        while (!o_byte_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("byte_accept", {31'h0, o_byte_ready}, 32'h1);
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (n_done < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", n_done, target);
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_done", {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", {31'h0, o_byte_ready}, 32'h0);
        chk("rst_ext_we",     {31'h0, o_ext_we}, 32'h0);
        chk("rst_ext_addr",   {16'h0, o_ext_addr}, 32'h0);
        chk("rst_ext_data",   {24'h0, o_ext_data}, 32'h0);
        chk("rst_busy",       {31'h0, o_busy}, 32'h0);
        chk("rst_done",       {31'h0, o_done}, 32'h0);
        chk("rst_err",        {31'h0, o_err}, 32'h0);
        chk("rst_end_addr",   {16'h0, o_end_addr}, 32'h0);
        rst = 1'b0;

        // Basic load at $0801.
        ack_delay = 3;
        exp_wr(16'h0801, 8'hAA);
        exp_wr(16'h0802, 8'hBB);
        exp_wr(16'h0803, 8'hCC);
        exp_done(1'b0, 16'h0804);
        start();
        chk("busy_after_start", {31'h0, o_busy}, 32'h1);
        send(8'h01, 0); send(8'h08, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
        wait_done(1);

        // Slow acknowledge; a start pulse mid-write must be ignored.
        ack_delay = 20;
        exp_wr(16'h1000, 8'h5A);
        exp_done(1'b0, 16'h1001);
        start();
        send(8'h00, 0); send(8'h10, 0); send(8'h5A, 1);
        repeat (5) @(negedge clk);
        start();
        wait_done(2);

        // Address wrap: two writes, the rest drained.
        ack_delay = 3;
        exp_wr(16'hFFFE, 8'h11);
        exp_wr(16'hFFFF, 8'h22);
        exp_done(1'b1, 16'h0000);
        start();
        send(8'hFE, 0); send(8'hFF, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        wait_done(3);

        // Truncated header.
        exp_done(1'b1, 16'h0000);
        start();
        send(8'h01, 1);
        wait_done(4);

        // Reset mid-write, then a clean load.
        ack_delay = 20;
        exp_wr(16'h2000, 8'h77);
        start();
        send(8'h00, 0); send(8'h20, 0); send(8'h77, 0);
        repeat (4) @(negedge clk);
        chk("we_before_rst", {31'h0, o_ext_we}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("we_after_rst", {31'h0, o_ext_we}, 32'h0);
        chk("busy_after_rst", {31'h0, o_busy}, 32'h0);
        rst = 1'b0;
        ack_delay = 3;
        exp_wr(16'hC000, 8'h55);
        exp_done(1'b0, 16'hC001);
        start();
        send(8'h00, 0); send(8'hC0, 0); send(8'h55, 1);
        wait_done(5);

        // Single-byte program; exercises the BASIC pointer update when enabled.
        exp_wr(16'h0801, 8'hEA);
        exp_done(1'b0, 16'h0802);
        start();
        send(8'h01, 0); send(8'h08, 0); send(8'hEA, 1);
        wait_done(6);

        chk("writes_outstanding", q_wr.size(), 0);
        chk("dones_outstanding", q_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
